// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: bus widths,
// funct codes for the HI/LO instruction group and the sequencer states.
package muldiv_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;
  localparam int PROD_W  = 64;
  localparam int REM_W   = 33;

  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_mul(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [FUNCT_W-1:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Connection between the EX stage (master) and the multiply/divide unit (slave).
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic [FUNCT_W-1:0] funct;
  logic [DATA_W-1:0]  operand_1;
  logic [DATA_W-1:0]  operand_2;
  logic               start;
  logic               flush;
  logic               stall;
  logic               done;
  logic [DATA_W-1:0]  hi;
  logic [DATA_W-1:0]  lo;

  modport master (
    output funct, operand_1, operand_2, start, flush,
    input  stall, done, hi, lo
  );

  modport slave (
    input  funct, operand_1, operand_2, start, flush,
    output stall, done, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// 32-cycle iterative multiplier / restoring divider owning the HI/LO registers.
// Multiply and divide steps share a single 33-bit adder/subtractor.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  state_t              state, state_next;
  logic [4:0]          count;
  logic [PROD_W-1:0]   acc;
  logic [DATA_W-1:0]   operand_b;
  logic                is_mul_op, neg_main, neg_rem;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                go, stall_c, done_c;

  logic                mul_now, sgn_now, dz_now;
  logic [DATA_W-1:0]   mag_1, mag_2;
  logic                sub;
  logic [REM_W-1:0]    add_a, add_b, add_sum;
  logic [PROD_W-1:0]   acc_step, prod_fix;
  logic [DATA_W-1:0]   hi_fix, lo_fix;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    stall_c    = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && is_muldiv(bus.funct) && !bus.flush) begin
          go         = 1'b1;
          stall_c    = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        stall_c = 1'b1;
        if (count == 5'd31) state_next = ST_SIGN;
      end
      ST_SIGN: begin
        done_c     = !bus.flush;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (bus.flush) state_next = ST_IDLE;
    if (rst) begin
      go      = 1'b0;
      stall_c = 1'b0;
      done_c  = 1'b0;
    end
  end

  // Divide-by-zero keeps the raw dividend so the restoring loop leaves it as
  // the remainder and produces an all-ones quotient with no sign fix.
  always_comb begin
    mul_now = is_mul(bus.funct);
    sgn_now = is_signed_op(bus.funct);
    dz_now  = !mul_now && (bus.operand_2 == '0);
    mag_1   = (sgn_now && bus.operand_1[DATA_W-1] && !dz_now) ? -bus.operand_1 : bus.operand_1;
    mag_2   = (sgn_now && bus.operand_2[DATA_W-1]) ? -bus.operand_2 : bus.operand_2;
  end

  always_comb begin
    sub     = !is_mul_op;
    add_a   = is_mul_op ? {1'b0, acc[63:32]} : {acc[63:32], acc[31]};
    add_b   = {1'b0, operand_b};
    add_sum = add_a + (add_b ^ {REM_W{sub}}) + {{(REM_W-1){1'b0}}, sub};
    if (is_mul_op)
      acc_step = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};
    else
      acc_step = !add_sum[REM_W-1] ? {add_sum[31:0], acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    prod_fix = neg_main ? -acc : acc;
    hi_fix   = is_mul_op ? prod_fix[63:32] : (neg_rem  ? -acc[63:32] : acc[63:32]);
    lo_fix   = is_mul_op ? prod_fix[31:0]  : (neg_main ? -acc[31:0]  : acc[31:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      acc       <= '0;
      operand_b <= '0;
      is_mul_op <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            count     <= '0;
            acc       <= {{DATA_W{1'b0}}, mul_now ? mag_2 : mag_1};
            operand_b <= mul_now ? mag_1 : mag_2;
            is_mul_op <= mul_now;
            neg_main  <= sgn_now && !dz_now && (bus.operand_1[DATA_W-1] ^ bus.operand_2[DATA_W-1]);
            neg_rem   <= sgn_now && !dz_now && !mul_now && bus.operand_1[DATA_W-1];
          end else if (bus.start && bus.funct == FUNCT_MTHI) begin
            hi_q <= bus.operand_1;
          end else if (bus.start && bus.funct == FUNCT_MTLO) begin
            lo_q <= bus.operand_1;
          end
        end
        ST_CALC: begin
          count <= count + 5'd1;
          acc   <= acc_step;
        end
        ST_SIGN: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: count <= '0;
      endcase
    end
  end

  assign bus.stall = stall_c;
  assign bus.done  = done_c;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO pairs are queued when an
// operation is issued and compared once the unit has written HI/LO.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst;
  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.funct     = 6'h00;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
  endtask

  // Reference behaviour of the unit in plain arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    case (f)
      FUNCT_MULT: begin
        p = 64'(sa) * 64'(sb);
        return p;
      end
      FUNCT_MULTU: return {32'h0, a} * {32'h0, b};
      FUNCT_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Issues one operation and follows it until HI/LO are written (bounded).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int stall_cycles, output int done_cycle,
                        output logic [31:0] hi_obs, output logic [31:0] lo_obs);
    int cyc;
    bit finished;
    bus.funct     = f;
    bus.operand_1 = a;
    bus.operand_2 = b;
    bus.start     = 1'b1;
    #1;
    stall_cycles = 0;
    done_cycle   = -1;
    hi_obs       = bus.hi;
    lo_obs       = bus.lo;
    cyc          = 0;
    finished     = 1'b0;
    while (!finished && cyc < 80) begin
      if (bus.stall) stall_cycles++;
      if (bus.done) begin
        done_cycle = cyc;
        finished   = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      if (finished) begin
        hi_obs = bus.hi;
        lo_obs = bus.lo;
      end else begin
        #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.funct     = FUNCT_MULT;
    bus.operand_1 = 32'd5;
    bus.operand_2 = 32'd7;
    tick();
    tick();
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_multu_max();
    int sc, dc;
    logic [31:0] h, l;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (sc !== 33) begin errors++; $display("FAIL multu_stall_cycles: got %0d expected 33", sc); end
    checks++; if (dc !== 33) begin errors++; $display("FAIL multu_done_cycle: got %0d expected 33", dc); end
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL multu_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL multu_lo: got %h expected %h", l, e[31:0]); end
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL multu_stall_after: got %b expected 0", bus.stall); end
    tick();
  endtask

  task automatic test_mult_signed();
    int sc, dc;
    logic [31:0] h, l;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (dc !== 33) begin errors++; $display("FAIL mult_done_cycle: got %0d expected 33", dc); end
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL mult_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL mult_lo: got %h expected %h", l, e[31:0]); end
  endtask

  task automatic test_divide();
    int sc, dc;
    logic [31:0] h, l;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL div_neg_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL div_neg_lo: got %h expected %h", l, e[31:0]); end
    exp_q.push_back({32'd2, 32'd14});
    run_op(FUNCT_DIVU, 32'd100, 32'd7, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL divu_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL divu_lo: got %h expected %h", l, e[31:0]); end
  endtask

  task automatic test_div_boundaries();
    int sc, dc;
    logic [31:0] h, l;
    logic [63:0] e;
    exp_q.push_back({32'd5, 32'hFFFF_FFFF});
    run_op(FUNCT_DIVU, 32'd5, 32'd0, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (dc !== 33) begin errors++; $display("FAIL divu_zero_done_cycle: got %0d expected 33", dc); end
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL divu_zero_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL divu_zero_lo: got %h expected %h", l, e[31:0]); end
    exp_q.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op(FUNCT_DIV, 32'hFFFF_FFFB, 32'd0, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL div_zero_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL div_zero_lo: got %h expected %h", l, e[31:0]); end
    exp_q.push_back({32'h0, 32'h8000_0000});
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", l, e[31:0]); end
  endtask

  task automatic test_flush_restart();
    int sc, dc;
    bit done_seen;
    logic [31:0] h, l;
    logic [63:0] e;
    bus.funct = FUNCT_MTLO; bus.operand_1 = 32'h0; bus.start = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mtlo_stall: got %b expected 0", bus.stall); end
    tick();
    bus.funct = FUNCT_MTHI; bus.operand_1 = 32'h1234;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b expected 0", bus.stall); end
    tick();
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h expected %h", bus.hi, 32'h1234); end
    done_seen = 1'b0;
    bus.funct = FUNCT_MULT; bus.operand_1 = 32'd6; bus.operand_2 = 32'd7; bus.start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.done) done_seen = 1'b1;
      tick();
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    #1;
    if (bus.done) done_seen = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall_next: got %b expected 0", bus.stall); end
    checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL flush_hi: got %h expected %h", bus.hi, 32'h1234); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL flush_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL flush_done_seen: got %b expected 0", done_seen); end
    tick();
    exp_q.push_back({32'h0, 32'd6});
    run_op(FUNCT_MULTU, 32'd2, 32'd3, sc, dc, h, l);
    e = exp_q.pop_front();
    checks++; if (dc !== 33) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 33", dc); end
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL restart_hi: got %h expected %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL restart_lo: got %h expected %h", l, e[31:0]); end
  endtask

  task automatic test_flush_sign();
    bus.funct = FUNCT_MTHI; bus.operand_1 = 32'hAAAA; bus.start = 1'b1;
    tick();
    bus.funct = FUNCT_MTLO; bus.operand_1 = 32'h5555;
    tick();
    bus.funct = FUNCT_DIVU; bus.operand_1 = 32'd100; bus.operand_2 = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (32) tick();
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL sign_flush_done: got %b expected 0", bus.done); end
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.hi !== 32'hAAAA) begin errors++; $display("FAIL sign_flush_hi: got %h expected %h", bus.hi, 32'hAAAA); end
    checks++; if (bus.lo !== 32'h5555) begin errors++; $display("FAIL sign_flush_lo: got %h expected %h", bus.lo, 32'h5555); end
    bus.funct = FUNCT_MTHI; bus.operand_1 = 32'hBEEF; bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.hi !== 32'hAAAA) begin errors++; $display("FAIL flush_beats_mthi: got %h expected %h", bus.hi, 32'hAAAA); end
    tick();
  endtask

  task automatic test_reset_mid_calc();
    bit done_seen;
    bus.funct = FUNCT_MTHI; bus.operand_1 = 32'h77; bus.start = 1'b1;
    tick();
    bus.funct = FUNCT_MULTU; bus.operand_1 = 32'hFFFF_FFFF; bus.operand_2 = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    bus.start = 1'b1; bus.funct = FUNCT_MULTU; bus.operand_1 = 32'd3; bus.operand_2 = 32'd3;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    #1;
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", bus.stall); end
    done_seen = 1'b0;
    repeat (40) begin
      tick();
      #1;
      if (bus.done) done_seen = 1'b1;
    end
    tick();
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rst_start_ignored: got %b expected 0", done_seen); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_start_lo: got %h expected %h", bus.lo, 32'h0); end
  endtask

  task automatic test_back_to_back();
    int sc, dc;
    logic [31:0] h, l, a, b;
    logic [5:0] f;
    logic [63:0] e;
    logic [5:0] ops [4];
    ops[0] = FUNCT_MULT; ops[1] = FUNCT_MULTU; ops[2] = FUNCT_DIV; ops[3] = FUNCT_DIVU;
    for (int i = 0; i < 8; i++) begin
      f = ops[i % 4];
      a = $urandom;
      b = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) b = -b;
      exp_q.push_back(model(f, a, b));
      run_op(f, a, b, sc, dc, h, l);
      e = exp_q.pop_front();
      checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_done_cycle[%0d]: got %0d expected 33", i, dc); end
      checks++; if (h !== e[63:32]) begin errors++; $display("FAIL b2b_hi[%0d] f=%h a=%h b=%h: got %h expected %h", i, f, a, b, h, e[63:32]); end
      checks++; if (l !== e[31:0]) begin errors++; $display("FAIL b2b_lo[%0d] f=%h a=%h b=%h: got %h expected %h", i, f, a, b, l, e[31:0]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_divide();
    test_div_boundaries();
    test_flush_restart();
    test_flush_sign();
    test_reset_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
